// File: rtl/accel_responder_model_if.sv
// Request/response bus between a CVA6-style dispatcher and the accelerator stand-in.
// Latency: none, wires only.
// Backpressure: valid/ready on both directions; the responder side owns ready on requests.
interface accel_responder_model_if;
    logic [31:0] acc_req_insn_i;
    logic [63:0] acc_req_rs1_i;
    logic        acc_req_valid_i;
    logic        acc_req_ready_o;
    logic [31:0] acc_resp_insn_o;
    logic [63:0] acc_resp_result_o;
    logic        acc_resp_valid_o;
    logic        acc_resp_ready_i;
    logic        idle_o;
    logic [31:0] req_cnt_o;
    logic [31:0] resp_cnt_o;

    // Accelerator (responder) side.
    modport slave (
        input  acc_req_insn_i,
        input  acc_req_rs1_i,
        input  acc_req_valid_i,
        output acc_req_ready_o,
        output acc_resp_insn_o,
        output acc_resp_result_o,
        output acc_resp_valid_o,
        input  acc_resp_ready_i,
        output idle_o,
        output req_cnt_o,
        output resp_cnt_o
    );

    // Dispatcher (requester) side.
    modport master (
        output acc_req_insn_i,
        output acc_req_rs1_i,
        output acc_req_valid_i,
        input  acc_req_ready_o,
        input  acc_resp_insn_o,
        input  acc_resp_result_o,
        input  acc_resp_valid_o,
        output acc_resp_ready_i,
        input  idle_o,
        input  req_cnt_o,
        input  resp_cnt_o
    );
endinterface

// File: rtl/accel_responder_model.sv
// Accelerator stand-in: queues requests in order and answers each with rs1 ^ insn.
// Latency: response valid no earlier than Latency cycles after the request handshake.
// Backpressure: request ready drops when the queue is full; head response held until popped.
module accel_responder_model #(
    parameter int unsigned Depth   = 4,
    parameter int unsigned Latency = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    accel_responder_model_if.slave  bus
);

    localparam int unsigned PtrW    = $clog2(Depth);
    localparam logic [7:0]  CntInit = 8'(Latency - 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [PtrW:0]   fill_t;

    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    fill_t       fill_q, fill_d;
    logic [7:0]  cnt_q [Depth];
    logic [7:0]  cnt_d [Depth];
    logic [31:0] req_cnt_q, req_cnt_d;
    logic [31:0] resp_cnt_q, resp_cnt_d;

    // Payload is only ever read once its slot is resident, so it carries no reset.
    logic [31:0] insn_mem [Depth];
    logic [63:0] rs1_mem  [Depth];

    logic full, empty, req_ready, resp_valid, push, pop;

    assign full       = (fill_q == fill_t'(Depth));
    assign empty      = (fill_q == '0);
    // Ready looks only at registered fill, so a pop at full opens ready one cycle later.
    assign req_ready  = !full;
    assign resp_valid = !empty && (cnt_q[rd_ptr_q] == 8'd0);
    assign push       = bus.acc_req_valid_i && req_ready;
    assign pop        = resp_valid && bus.acc_resp_ready_i;

    assign bus.acc_req_ready_o   = req_ready;
    assign bus.acc_resp_valid_o  = resp_valid;
    assign bus.acc_resp_insn_o   = insn_mem[rd_ptr_q];
    assign bus.acc_resp_result_o = rs1_mem[rd_ptr_q] ^ {32'b0, insn_mem[rd_ptr_q]};
    assign bus.idle_o            = empty;
    assign bus.req_cnt_o         = req_cnt_q;
    assign bus.resp_cnt_o        = resp_cnt_q;

    // Next-state for pointers, fill level, per-slot countdowns and counters.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        req_cnt_d  = req_cnt_q;
        resp_cnt_d = resp_cnt_q;

        if (push) begin
            wr_ptr_d  = wr_ptr_q + ptr_t'(1);
            req_cnt_d = req_cnt_q + 32'd1;
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + ptr_t'(1);
            resp_cnt_d = resp_cnt_q + 32'd1;
        end

        case ({push, pop})
            2'b10:   fill_d = fill_q + fill_t'(1);
            2'b01:   fill_d = fill_q - fill_t'(1);
            default: fill_d = fill_q;
        endcase

        // Every slot ages on its own, so entries behind a stalled head still expire.
        // Stale slots may count down too; a push always reloads before the slot is read.
        for (int unsigned i = 0; i < Depth; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_q[i] != 8'd0) begin
                cnt_d[i] = cnt_q[i] - 8'd1;
            end
            if (push && (ptr_t'(i) == wr_ptr_q)) begin
                cnt_d[i] = CntInit;
            end
        end
    end

    // Control state register; reset discards every resident entry at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            req_cnt_q  <= '0;
            resp_cnt_q <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            req_cnt_q  <= req_cnt_d;
            resp_cnt_q <= resp_cnt_d;
            for (int unsigned i = 0; i < Depth; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Payload write on request handshake.
    always_ff @(posedge clk_i) begin
        if (push) begin
            insn_mem[wr_ptr_q] <= bus.acc_req_insn_i;
            rs1_mem[wr_ptr_q]  <= bus.acc_req_rs1_i;
        end
    end

endmodule

// File: tb/tb_accel_responder_model.sv
// Bench for accel_responder_model: two instances (Latency 3 and Latency 1, Depth 4).
// A queue-based model predicts every output each cycle; directed literals pin the model.
module tb_accel_responder_model;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] insn;
        logic [63:0] rs1;
        int          t;
    } ent_t;

    logic clk;
    logic rst_n;

    logic [31:0] req_insn [2];
    logic [63:0] req_rs1  [2];
    logic        req_vld  [2];
    logic        resp_rdy [2];

    logic        o_rdy  [2];
    logic        o_vld  [2];
    logic        o_idle [2];
    logic [31:0] o_insn [2];
    logic [63:0] o_res  [2];
    logic [31:0] o_rcnt [2];
    logic [31:0] o_pcnt [2];

    int tests;
    int fails;

    accel_responder_model_if ifc0 ();
    accel_responder_model_if ifc1 ();

    accel_responder_model #(.Depth(DEPTH), .Latency(3)) u_dut0 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifc0)
    );

    accel_responder_model #(.Depth(DEPTH), .Latency(1)) u_dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifc1)
    );

    assign ifc0.acc_req_insn_i   = req_insn[0];
    assign ifc0.acc_req_rs1_i    = req_rs1[0];
    assign ifc0.acc_req_valid_i  = req_vld[0];
    assign ifc0.acc_resp_ready_i = resp_rdy[0];
    assign ifc1.acc_req_insn_i   = req_insn[1];
    assign ifc1.acc_req_rs1_i    = req_rs1[1];
    assign ifc1.acc_req_valid_i  = req_vld[1];
    assign ifc1.acc_resp_ready_i = resp_rdy[1];

    assign o_rdy[0]  = ifc0.acc_req_ready_o;
    assign o_vld[0]  = ifc0.acc_resp_valid_o;
    assign o_idle[0] = ifc0.idle_o;
    assign o_insn[0] = ifc0.acc_resp_insn_o;
    assign o_res[0]  = ifc0.acc_resp_result_o;
    assign o_rcnt[0] = ifc0.req_cnt_o;
    assign o_pcnt[0] = ifc0.resp_cnt_o;
    assign o_rdy[1]  = ifc1.acc_req_ready_o;
    assign o_vld[1]  = ifc1.acc_resp_valid_o;
    assign o_idle[1] = ifc1.idle_o;
    assign o_insn[1] = ifc1.acc_resp_insn_o;
    assign o_res[1]  = ifc1.acc_resp_result_o;
    assign o_rcnt[1] = ifc1.req_cnt_o;
    assign o_pcnt[1] = ifc1.resp_cnt_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    ent_t mq [2][$];
    int   mreq  [2];
    int   mresp [2];
    int   lat   [2];
    int   cyc;

    initial begin
        lat[0] = 3;
        lat[1] = 1;
        cyc    = 0;
        mreq   = '{0, 0};
        mresp  = '{0, 0};
    end

    // An entry handshaked in cycle t answers from cycle t+Latency if it is at the head.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic e_rdy;
            logic e_vld;
            ent_t e;
            if (!rst_n) begin
                mq[d].delete();
                mreq[d]  = 0;
                mresp[d] = 0;
            end
            e_rdy = (mq[d].size() < DEPTH);
            e_vld = (mq[d].size() > 0) && (cyc >= mq[d][0].t + lat[d]);
            chk($sformatf("d%0d ready", d), o_rdy[d], e_rdy);
            chk($sformatf("d%0d valid", d), o_vld[d], e_vld);
            chk($sformatf("d%0d idle", d), o_idle[d], mq[d].size() == 0);
            chk($sformatf("d%0d req_cnt", d), o_rcnt[d], mreq[d]);
            chk($sformatf("d%0d resp_cnt", d), o_pcnt[d], mresp[d]);
            if (e_vld) begin
                chk($sformatf("d%0d resp_insn", d), o_insn[d], mq[d][0].insn);
                chk($sformatf("d%0d resp_result", d), o_res[d],
                    mq[d][0].rs1 ^ {32'b0, mq[d][0].insn});
            end
            if (rst_n) begin
                if (e_vld && resp_rdy[d]) begin
                    void'(mq[d].pop_front());
                    mresp[d]++;
                end
                if (req_vld[d] && e_rdy) begin
                    e.insn = req_insn[d];
                    e.rs1  = req_rs1[d];
                    e.t    = cyc;
                    mq[d].push_back(e);
                    mreq[d]++;
                end
            end
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_insn[d] = '0;
            req_rs1[d]  = '0;
            req_vld[d]  = 1'b0;
            resp_rdy[d] = 1'b0;
        end
        repeat (3) tick();
        chk("reset ready", o_rdy[0], 1);
        chk("reset valid", o_vld[0], 0);
        chk("reset idle", o_idle[0], 1);
        chk("reset req_cnt", o_rcnt[0], 0);
        chk("reset resp_cnt", o_pcnt[0], 0);
        rst_n = 1'b1;
        tick();

        // Streaming on the Latency=1 instance: one response per cycle, pointers wrap twice.
        resp_rdy[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_vld[1]  = 1'b1;
            req_insn[1] = 32'h1000 + i;
            req_rs1[1]  = 64'hA5A5_0000_0000_0000 + 64'(i);
            tick();
            if (i == 0) begin
                chk("stream first valid", o_vld[1], 1);
                chk("stream first insn", o_insn[1], 64'h1000);
                chk("stream first result", o_res[1], 64'hA5A5_0000_0000_1000);
            end
        end
        req_vld[1] = 1'b0;
        tick();
        chk("stream req_cnt", o_rcnt[1], 10);
        chk("stream resp_cnt", o_pcnt[1], 10);
        chk("stream idle", o_idle[1], 1);
        resp_rdy[1] = 1'b0;

        // Single request on the Latency=3 instance.
        req_vld[0]  = 1'b1;
        req_insn[0] = 32'h0000_0057;
        req_rs1[0]  = 64'h1;
        resp_rdy[0] = 1'b1;
        tick();
        req_vld[0] = 1'b0;
        tick();
        chk("single early valid", o_vld[0], 0);
        tick();
        chk("single valid", o_vld[0], 1);
        chk("single insn", o_insn[0], 64'h57);
        chk("single result", o_res[0], 64'h56);
        tick();
        chk("single idle", o_idle[0], 1);
        chk("single req_cnt", o_rcnt[0], 1);
        chk("single resp_cnt", o_pcnt[0], 1);

        // Fill to full with responses stalled.
        resp_rdy[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_vld[0]  = 1'b1;
            req_insn[0] = 32'h200 + i;
            req_rs1[0]  = 64'h0123_4567_89AB_CD00 + 64'(i);
            tick();
        end
        chk("full ready", o_rdy[0], 0);
        req_insn[0] = 32'h204;
        req_rs1[0]  = 64'h0123_4567_89AB_CD04;
        repeat (20) tick();
        chk("stall valid", o_vld[0], 1);
        chk("stall insn", o_insn[0], 64'h200);
        chk("stall result", o_res[0], 64'h0123_4567_89AB_CF00);
        chk("stall idle", o_idle[0], 0);
        chk("stall req_cnt", o_rcnt[0], 5);
        chk("stall resp_cnt", o_pcnt[0], 1);
        chk("stall ready", o_rdy[0], 0);

        // Pop from full: ready stays low this cycle, opens next cycle.
        resp_rdy[0] = 1'b1;
        #1;
        chk("pop-at-full ready", o_rdy[0], 0);
        tick();
        chk("after pop ready", o_rdy[0], 1);
        tick();
        req_vld[0] = 1'b0;
        for (int k = 0; k < 40 && !o_idle[0]; k++) tick();
        chk("drain idle", o_idle[0], 1);
        chk("drain req_cnt", o_rcnt[0], 6);
        chk("drain resp_cnt", o_pcnt[0], 6);

        // Aging behind a stalled head.
        resp_rdy[0] = 1'b0;
        req_vld[0]  = 1'b1;
        req_insn[0] = 32'h300;
        req_rs1[0]  = 64'h3;
        tick();
        req_insn[0] = 32'h301;
        req_rs1[0]  = 64'h30;
        tick();
        req_vld[0] = 1'b0;
        repeat (4) tick();
        resp_rdy[0] = 1'b1;
        #1;
        chk("aging A valid", o_vld[0], 1);
        chk("aging A insn", o_insn[0], 64'h300);
        tick();
        chk("aging B valid", o_vld[0], 1);
        chk("aging B insn", o_insn[0], 64'h301);
        chk("aging B result", o_res[0], 64'h331);
        tick();
        chk("aging idle", o_idle[0], 1);

        // Reset with three resident entries.
        resp_rdy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_vld[0]  = 1'b1;
            req_insn[0] = 32'h400 + i;
            req_rs1[0]  = 64'h40 + 64'(i);
            tick();
        end
        req_vld[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst valid", o_vld[0], 0);
        chk("midrst ready", o_rdy[0], 1);
        chk("midrst idle", o_idle[0], 1);
        chk("midrst req_cnt", o_rcnt[0], 0);
        chk("midrst resp_cnt", o_pcnt[0], 0);
        repeat (2) tick();
        rst_n       = 1'b1;
        req_vld[0]  = 1'b1;
        req_insn[0] = 32'h500;
        req_rs1[0]  = 64'h5;
        tick();
        req_vld[0] = 1'b0;
        tick();
        chk("post-rst early valid", o_vld[0], 0);
        tick();
        chk("post-rst valid", o_vld[0], 1);
        chk("post-rst result", o_res[0], 64'h505);
        resp_rdy[0] = 1'b1;
        tick();
        chk("post-rst idle", o_idle[0], 1);
        chk("post-rst req_cnt", o_rcnt[0], 1);
        chk("post-rst resp_cnt", o_pcnt[0], 1);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
